rv_fetch_seq: RTL and testbench

Fetch sequencer in front of the instruction fetch buffer. Owns the fetch PC, issues word-aligned instruction-bus reads only when the buffer can absorb the returned halfwords, and tags each returning word with its fetch address. On a PC redirect it discards every stale in-flight response before forwarding new data to the buffer.

---
 rtl/rv_fetch_pkg.sv | 24 ++
 rtl/rv_fetch_seq_if.sv | 31 +++
 rtl/rv_fetch_tag_fifo.sv | 54 +++++
 rtl/rv_fetch_seq.sv | 128 ++++++++++++
 tb/tb_rv_fetch_seq.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// ======================================================================
// rv_fetch_pkg : types shared by the fetch sequencer and its tag FIFO
// rev 1.0
// ======================================================================
package rv_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_seq_state_t;

   typedef struct packed {
      logic [31:0] pc;
   } fetch_tag_t;

   // A fetch from an odd-halfword PC only yields the upper halfword of the word.
   function automatic logic [1:0] need_hw(input logic i_pc1);
      return i_pc1 ? 2'd1 : 2'd2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv_fetch_seq_if.sv
`default_nettype none
// ======================================================================
// rv_fetch_seq_if : instruction-bus read channel of the fetch sequencer
// rev 1.0
// ======================================================================
interface rv_fetch_seq_if;

   logic        req;
   logic [31:0] addr;
   logic        req_ready;
   logic        ack;
   logic [31:0] data;

   modport master (
      output req,
      output addr,
      input  req_ready,
      input  ack,
      input  data
   );

   modport slave (
      input  req,
      input  addr,
      output req_ready,
      output ack,
      output data
   );

endinterface
`default_nettype wire

// File: rtl/rv_fetch_tag_fifo.sv
`default_nettype none
// ======================================================================
// rv_fetch_tag_fifo : in-order fetch-address tags for outstanding reads
// rev 1.0
// ======================================================================
module rv_fetch_tag_fifo
   import rv_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clear,
   input  logic       i_push,
   input  fetch_tag_t i_push_tag,
   input  logic       i_pop,
   output fetch_tag_t o_head,
   output logic       o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_tag_t    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i_p);
      return (i_p == PW'(DEPTH - 1)) ? '0 : i_p + PW'(1);
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_push_tag;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rv_fetch_seq.sv
`default_nettype none
// ======================================================================
// rv_fetch_seq : fetch PC owner, credit-gated bus issue, redirect drain
// rev 1.0
// ======================================================================
module rv_fetch_seq
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          BUF_ADDR_SIZE   = 2
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   rv_fetch_seq_if.master         bus,
   input  logic                   i_pc_select,
   input  logic [31:0]            i_pc_target,
   input  logic                   i_flush,
   input  logic [BUF_ADDR_SIZE:0] i_buf_free_hw,
   output logic                   o_ack,
   output logic [31:0]            o_data,
   output logic [31:0]            o_fetch_pc,
   output logic                   o_fetch_pc1,
   output logic                   o_err
);

   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int IW  = BUF_ADDR_SIZE + 2;
   localparam int CRW = IW + 1;

   fetch_seq_state_t r_state;
   logic [31:0]      r_pc;
   logic [OW-1:0]    r_outstanding;
   logic [OW-1:0]    r_discard;
   logic [IW-1:0]    r_inflight_hw;
   logic             r_err;

   fetch_tag_t       w_head;
   logic             w_fifo_empty;
   logic [1:0]       w_need;
   logic [1:0]       w_pop_need;
   logic             w_credit_ok;
   logic             w_can_issue;
   logic             w_issue;
   logic             w_pop;
   logic             w_stray;
   logic [31:0]      w_target;
   logic [OW-1:0]    w_discard_new;

   assign w_need      = need_hw(r_pc[1]);
   assign w_pop_need  = need_hw(w_head.pc[1]);
   assign w_credit_ok = CRW'(i_buf_free_hw) >= (CRW'(r_inflight_hw) + CRW'(w_need));
   assign w_can_issue = (r_state == RUN) && !i_flush && !i_pc_select &&
                        (r_outstanding < OW'(MAX_OUTSTANDING)) && w_credit_ok;
   assign w_issue     = w_can_issue && bus.req_ready;
   assign w_pop       = bus.ack && (r_state == RUN) && !i_pc_select &&
                        (r_outstanding != '0) && !w_fifo_empty;
   assign w_stray     = bus.ack && (r_outstanding == '0) && (r_discard == '0);
   assign w_target    = i_pc_target & 32'hFFFF_FFFE;
   // An ack landing in the redirect cycle is itself one of the stale responses.
   assign w_discard_new = r_outstanding - OW'(bus.ack && (r_outstanding != '0));

   assign bus.req     = w_can_issue;
   assign bus.addr    = {r_pc[31:2], 2'b00};
   assign o_ack       = w_pop;
   assign o_data      = bus.data;
   assign o_fetch_pc  = w_pop ? w_head.pc : 32'h0;
   assign o_fetch_pc1 = r_pc[1];
   assign o_err       = r_err;

   rv_fetch_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (i_pc_select),
      .i_push     (w_issue),
      .i_push_tag (fetch_tag_t'(r_pc)),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_empty    (w_fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= BOOT;
         r_pc          <= RESET_ADDR;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_inflight_hw <= '0;
         r_err         <= 1'b0;
      end else begin
         if (w_stray) r_err <= 1'b1;
         case (r_state)
            BOOT: begin
               r_state <= RUN;
               if (i_pc_select) r_pc <= w_target;
            end
            RUN: begin
               if (i_pc_select) begin
                  r_pc          <= w_target;
                  r_outstanding <= '0;
                  r_inflight_hw <= '0;
                  r_discard     <= w_discard_new;
                  r_state       <= (w_discard_new != '0) ? DRAIN : RUN;
               end else begin
                  if (w_issue) r_pc <= r_pc + {29'd0, w_need, 1'b0};
                  r_outstanding <= r_outstanding + OW'(w_issue) - OW'(w_pop);
                  r_inflight_hw <= r_inflight_hw
                                   + (w_issue ? IW'(w_need) : IW'(0))
                                   - (w_pop ? IW'(w_pop_need) : IW'(0));
               end
            end
            DRAIN: begin
               // A redirect here needs no extra discard: the old stream is already counted.
               if (i_pc_select) r_pc <= w_target;
               if (bus.ack) begin
                  r_discard <= r_discard - OW'(1);
                  if (r_discard == OW'(1)) r_state <= RUN;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rv_fetch_seq.sv
`default_nettype none
// ======================================================================
// tb_rv_fetch_seq : per-cycle vector table plus fetch-PC scoreboard
// rev 1.0
// ======================================================================
module tb_rv_fetch_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [31:0] tgt;
   logic        flush;
   logic [2:0]  free;
   logic        o_ack;
   logic [31:0] o_data;
   logic [31:0] o_fpc;
   logic        o_fpc1;
   logic        o_err;

   always #5 clk = ~clk;

   rv_fetch_seq_if bus ();

   rv_fetch_seq #(
      .RESET_ADDR      (32'h0000_0100),
      .MAX_OUTSTANDING (2),
      .BUF_ADDR_SIZE   (2)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .bus           (bus),
      .i_pc_select   (sel),
      .i_pc_target   (tgt),
      .i_flush       (flush),
      .i_buf_free_hw (free),
      .o_ack         (o_ack),
      .o_data        (o_data),
      .o_fetch_pc    (o_fpc),
      .o_fetch_pc1   (o_fpc1),
      .o_err         (o_err)
   );

   typedef struct {
      logic        sel;
      logic [31:0] tgt;
      logic        flush;
      logic [2:0]  free;
      logic        rdy;
      logic        ack;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_ack;
      logic        e_fpc1;
      logic        e_err;
      logic        push;
      logic [31:0] tag;
      logic        clr;
   } vec_t;

   vec_t        tbl[$];
   vec_t        v;
   logic [31:0] sb[$];
   logic [31:0] exp_pc;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input int s, input int t, input int fl, input int fr, input int rd,
                      input int ak, input int er, input int ea, input int eak, input int ep1,
                      input int eer, input int ps, input int tg, input int cl);
      vec_t x;
      x.sel = s[0];   x.tgt = 32'(t);     x.flush = fl[0]; x.free = 3'(fr);
      x.rdy = rd[0];  x.ack = ak[0];      x.e_req = er[0]; x.e_addr = 32'(ea);
      x.e_ack = eak[0]; x.e_fpc1 = ep1[0]; x.e_err = eer[0];
      x.push = ps[0]; x.tag = 32'(tg);    x.clr = cl[0];
      tbl.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //   sel tgt    fl fr rd ak | req addr   ack p1 err | push tag    clr
      add(0, 0,      0, 4, 1, 0,   0, 'h100,  0,  0, 0,    0, 0,      0); // BOOT
      add(0, 0,      0, 4, 1, 0,   1, 'h100,  0,  0, 0,    1, 'h100,  0);
      add(0, 0,      0, 4, 1, 0,   1, 'h104,  0,  0, 0,    1, 'h104,  0);
      add(0, 0,      0, 4, 1, 0,   0, 'h108,  0,  0, 0,    0, 0,      0); // full
      add(0, 0,      0, 4, 1, 1,   0, 'h108,  1,  0, 0,    0, 0,      0);
      add(0, 0,      0, 4, 0, 1,   1, 'h108,  1,  0, 0,    0, 0,      0);
      add(1, 'h202,  0, 4, 1, 0,   0, 'h108,  0,  0, 0,    0, 0,      0); // redirect, idle
      add(0, 0,      0, 4, 1, 0,   1, 'h200,  0,  1, 0,    1, 'h202,  0);
      add(0, 0,      0, 2, 1, 0,   0, 'h204,  0,  0, 0,    0, 0,      0); // credit 1 < 2
      add(0, 0,      0, 3, 1, 0,   1, 'h204,  0,  0, 0,    1, 'h204,  0);
      add(1, 'h400,  0, 4, 1, 0,   0, 'h208,  0,  0, 0,    0, 0,      1); // redirect, 2 out
      add(0, 0,      0, 4, 1, 1,   0, 'h400,  0,  0, 0,    0, 0,      0);
      add(0, 0,      0, 4, 1, 0,   0, 'h400,  0,  0, 0,    0, 0,      0);
      add(0, 0,      0, 4, 1, 1,   0, 'h400,  0,  0, 0,    0, 0,      0);
      add(0, 0,      0, 4, 1, 0,   1, 'h400,  0,  0, 0,    1, 'h400,  0);
      add(0, 0,      0, 4, 1, 1,   1, 'h404,  1,  0, 0,    1, 'h404,  0); // ack + issue
      add(0, 0,      0, 4, 1, 0,   1, 'h408,  0,  0, 0,    1, 'h408,  0);
      add(1, 'h600,  0, 4, 1, 1,   0, 'h40C,  0,  0, 0,    0, 0,      1); // redirect + ack
      add(0, 0,      0, 4, 1, 1,   0, 'h600,  0,  0, 0,    0, 0,      0);
      add(0, 0,      0, 4, 0, 0,   1, 'h600,  0,  0, 0,    0, 0,      0);
      add(0, 0,      0, 1, 1, 0,   0, 'h600,  0,  0, 0,    0, 0,      0); // free 1
      add(0, 0,      0, 2, 0, 0,   1, 'h600,  0,  0, 0,    0, 0,      0);
      add(0, 0,      1, 2, 1, 0,   0, 'h600,  0,  0, 0,    0, 0,      0); // flush
      add(0, 0,      0, 2, 0, 1,   1, 'h600,  0,  0, 0,    0, 0,      0); // stray ack
      add(0, 0,      0, 2, 0, 0,   1, 'h600,  0,  0, 1,    0, 0,      0);
      add(0, 0,      0, 2, 0, 0,   1, 'h600,  0,  0, 1,    0, 0,      0);

      rst = 1'b1; sel = 1'b0; tgt = '0; flush = 1'b0; free = 3'd4;
      bus.req_ready = 1'b1; bus.ack = 1'b0; bus.data = '0;
      tick();
      tick();
      chk("reset req",  32'(bus.req), 32'd0);
      chk("reset addr", bus.addr,     32'h100);
      chk("reset ack",  32'(o_ack),   32'd0);
      chk("reset fpc",  o_fpc,        32'd0);
      chk("reset fpc1", 32'(o_fpc1),  32'd0);
      chk("reset err",  32'(o_err),   32'd0);

      rst = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         sel = v.sel; tgt = v.tgt; flush = v.flush; free = v.free;
         bus.req_ready = v.rdy; bus.ack = v.ack; bus.data = 32'hD000_0000 + 32'(i);
         #1;
         chk($sformatf("v%0d req", i),  32'(bus.req), 32'(v.e_req));
         chk($sformatf("v%0d addr", i), bus.addr,     v.e_addr);
         chk($sformatf("v%0d ack", i),  32'(o_ack),   32'(v.e_ack));
         chk($sformatf("v%0d fpc1", i), 32'(o_fpc1),  32'(v.e_fpc1));
         chk($sformatf("v%0d err", i),  32'(o_err),   32'(v.e_err));
         if (v.e_ack) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL v%0d scoreboard: got ack, expected queue empty", i);
            end else begin
               exp_pc = sb.pop_front();
               chk($sformatf("v%0d fetch_pc", i), o_fpc,  exp_pc);
               chk($sformatf("v%0d data", i),     o_data, 32'hD000_0000 + 32'(i));
            end
         end
         if (v.clr)  sb.delete();
         if (v.push) sb.push_back(v.tag);
         @(posedge clk);
         #1;
      end

      // Reset clears the sticky error, then a redirect is cut short by reset mid-drain.
      rst = 1'b1; sel = 1'b0; flush = 1'b0; free = 3'd4; bus.req_ready = 1'b1; bus.ack = 1'b0;
      tick();
      chk("rst2 err",  32'(o_err),  32'd0);
      chk("rst2 addr", bus.addr,    32'h100);
      rst = 1'b0;
      #1;
      chk("boot req", 32'(bus.req), 32'd0);
      tick();
      chk("iss0 req",  32'(bus.req), 32'd1);
      chk("iss0 addr", bus.addr,     32'h100);
      tick();
      chk("iss1 addr", bus.addr,     32'h104);
      tick();
      sel = 1'b1; tgt = 32'h303;
      #1;
      chk("redir req", 32'(bus.req), 32'd0);
      tick();
      sel = 1'b0; bus.ack = 1'b1; bus.data = 32'hBAD0_0000;
      #1;
      chk("drain ack",  32'(o_ack),  32'd0);
      chk("drain addr", bus.addr,    32'h300);
      chk("drain fpc1", 32'(o_fpc1), 32'd1);
      chk("drain req",  32'(bus.req), 32'd0);
      tick();
      rst = 1'b1; bus.ack = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("rst3 req",  32'(bus.req), 32'd0);
      chk("rst3 addr", bus.addr,     32'h100);
      chk("rst3 fpc1", 32'(o_fpc1),  32'd0);
      tick();
      chk("rst3 iss", 32'(bus.req),  32'd1);
      tick();
      bus.req_ready = 1'b0; bus.ack = 1'b1; bus.data = 32'hCAFE_F00D;
      #1;
      chk("rst3 ack",  32'(o_ack), 32'd1);
      chk("rst3 fpc",  o_fpc,      32'h100);
      chk("rst3 data", o_data,     32'hCAFE_F00D);
      tick();
      bus.ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
